uart_mem_reader: RTL

- Avalon-MM read master that drains a byte buffer from the 32-bit on-chip memory slave and streams it, byte by byte, to the UART transmitter over a valid/ready interface.
- Sits between the memory's s1/s2 slave (via the interconnect) and the UART TX path.
- Software or the control FSM kicks it with a base word address and a byte count. It reports completion with a one-cycle done pulse.

---
 rtl/uart_mem_pkg.sv | 18 +
 rtl/uart_mem_byte_unpacker.sv | 36 +++
 rtl/uart_mem_reader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_mem_pkg.sv
// Types and constants shared by the UART memory reader and the memory wrapper.
// The CSUM state exists only when UART_MEM_READER_CSUM_EN is defined.
package uart_mem_pkg;
  localparam int MEM_DEPTH_WORDS = 5320;
  localparam int MEM_ADDR_W      = 13;
  localparam int BYTE_LANES      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_SEND,
`ifdef UART_MEM_READER_CSUM_EN
    ST_CSUM,
`endif
    ST_FIN
  } rd_state_t;
endpackage

// File: rtl/uart_mem_byte_unpacker.sv
// Holds one fetched 32-bit word and presents it little-endian, one byte per
// valid/ready handshake.
module uart_mem_byte_unpacker
  import uart_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        word_load,
  input  logic [31:0] word_in,
  input  logic        byte_en,
  input  logic        byte_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        last_lane
);
  localparam int LANE_W = $clog2(BYTE_LANES);

  logic [31:0]       word_q;
  logic [LANE_W-1:0] lane_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      lane_q <= '0;
    end else if (word_load) begin
      word_q <= word_in;
      lane_q <= '0;
    end else if (byte_en && byte_ready) begin
      lane_q <= lane_q + LANE_W'(1);
    end
  end

  assign byte_valid = byte_en;
  assign byte_data  = byte_en ? word_q[{lane_q, 3'b000} +: 8] : 8'h00;
  assign last_lane  = (lane_q == LANE_W'(BYTE_LANES - 1));
endmodule

// File: rtl/uart_mem_reader.sv
// Avalon-MM read master that streams a byte buffer from word memory to UART TX.
// Define UART_MEM_READER_CSUM_EN to append a modulo-256 checksum byte.
//
// state     | meaning
// IDLE      | waiting for start
// REQ       | avm_read asserted at pointer, held through waitrequest
// WAIT_DATA | one read outstanding, waiting for readdatavalid
// SEND      | presenting word bytes to UART TX, lane 0 first
// CSUM      | presenting checksum byte (optional build)
// FIN       | one-cycle done pulse
module uart_mem_reader
  import uart_mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DEPTH_WORDS = MEM_DEPTH_WORDS,
  parameter int CNT_W       = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_word_addr,
  input  logic [CNT_W-1:0]  byte_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              word_load, ptr_inc, send_fire, last_lane, byte_valid;
  logic [7:0]        byte_data;

  uart_mem_byte_unpacker u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .word_load  (word_load),
    .word_in    (avm_readdata),
    .byte_en    (state_q == ST_SEND),
    .byte_ready (tx_ready),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .last_lane  (last_lane)
  );

  assign send_fire = byte_valid && tx_ready;

`ifdef UART_MEM_READER_CSUM_EN
  logic [7:0] sum_q;
  localparam rd_state_t ST_LAST = ST_CSUM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         sum_q <= '0;
    else if (state_q == ST_IDLE && start) sum_q <= '0;
    else if (send_fire)                sum_q <= sum_q + byte_data;
  end

  assign tx_valid = byte_valid || (state_q == ST_CSUM);
  assign tx_data  = (state_q == ST_CSUM) ? sum_q : byte_data;
`else
  localparam rd_state_t ST_LAST = ST_FIN;

  assign tx_valid = byte_valid;
  assign tx_data  = byte_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        ptr_q       <= base_word_addr;
        remaining_q <= byte_count;
      end
      if (send_fire) remaining_q <= remaining_q - CNT_W'(1);
      // Word pointer wraps at the end of the memory, not at 2**ADDR_W.
      if (ptr_inc) ptr_q <= (ptr_q == ADDR_W'(DEPTH_WORDS - 1)) ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    word_load = 1'b0;
    ptr_inc   = 1'b0;
    avm_read  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = (byte_count == '0) ? ST_LAST : ST_REQ;
      ST_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: if (avm_readdatavalid) begin
        word_load = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: if (send_fire) begin
        if (remaining_q == CNT_W'(1)) state_d = ST_LAST;
        else if (last_lane) begin
          ptr_inc = 1'b1;
          state_d = ST_REQ;
        end
      end
`ifdef UART_MEM_READER_CSUM_EN
      ST_CSUM: if (tx_ready) state_d = ST_FIN;
`endif
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign avm_address = ptr_q;
endmodule
